deadtime_gen: RTL and testbench

//  Dead-time insertion stage directly downstream of the PWM comparator.
//  - Takes the raw comparator PWM (pwmout_A) and produces complementary gate

---
 rtl/deadtime_gen.sv | 160 ++++++++++++++++
 tb/tb_deadtime_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/deadtime_gen.sv
// -----------------------------------------------------------------------------
// deadtime_gen
//   Dead-time insertion stage that sits directly after the PWM comparator.
//   It turns the raw comparator output into complementary half-bridge gate
//   drives. Around every commutation it keeps both gates low for a
//   programmable number of clk cycles.
//
// Ports
//   clk        in   1          system clock, all logic on posedge
//   reset      in   1          synchronous, active-low reset
//   pwm_in     in   1          raw PWM request (1 = high side wanted)
//   dt_value   in   DT_WIDTH   dead time in clk cycles (0 = none)
//   pwm_onoff  in   1          PWM_ON enables the outputs, otherwise both low
//   dt_onoff   in   1          DT_ON enables the low-side gate, otherwise 0
//   pwm_hi     out  1          high-side gate, registered
//   pwm_lo     out  1          low-side gate, registered
//   dt_active  out  1          1 while the leg is in a dead-time state
// -----------------------------------------------------------------------------
module deadtime_gen #(
    parameter int DT_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dt_value,
    input  logic                pwm_onoff,
    input  logic                dt_onoff,
    output logic                pwm_hi,
    output logic                pwm_lo,
    output logic                dt_active
);

    localparam logic PWM_ON = 1'b1;
    localparam logic DT_ON  = 1'b1;

    localparam logic [DT_WIDTH-1:0] CNT_ZERO = {DT_WIDTH{1'b0}};
    localparam logic [DT_WIDTH-1:0] CNT_ONE  = {{(DT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HI    = 3'd1,
        ST_DT_HL = 3'd2,   // high side off, waiting to turn low side on
        ST_LO    = 3'd3,
        ST_DT_LH = 3'd4    // low side off, waiting to turn high side on
    } state_e;

    state_e              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                pwm_hi_q, pwm_hi_d;
    logic                pwm_lo_q, pwm_lo_d;
    logic                dt_active_q, dt_active_d;

    // Next-state, dead-time counter and next-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        if (pwm_onoff != PWM_ON) begin
            // Disable wins over every other transition, from any state.
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Start-up always goes through a dead-time phase, because
                    // the state of the opposite switch is not known.
                    if (dt_value == CNT_ZERO) begin
                        state_d = pwm_in ? ST_HI : ST_LO;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = pwm_in ? ST_DT_LH : ST_DT_HL;
                        cnt_d   = dt_value;
                    end
                end
                ST_HI: begin
                    if (!pwm_in) begin
                        if (dt_value == CNT_ZERO) begin
                            state_d = ST_LO;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            state_d = ST_DT_HL;
                            cnt_d   = dt_value;
                        end
                    end else begin
                        state_d = ST_HI;
                    end
                end
                ST_DT_HL: begin
                    if (pwm_in) begin
                        // Request reversed before the low side was ever on.
                        state_d = ST_HI;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = ST_LO;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                ST_LO: begin
                    if (pwm_in) begin
                        if (dt_value == CNT_ZERO) begin
                            state_d = ST_HI;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            state_d = ST_DT_LH;
                            cnt_d   = dt_value;
                        end
                    end else begin
                        state_d = ST_LO;
                    end
                end
                ST_DT_LH: begin
                    if (!pwm_in) begin
                        state_d = ST_LO;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = ST_HI;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        // Outputs come from the next state so that they update on the same
        // edge that samples the input. Both gates come from one state, so
        // they can never be on together.
        pwm_hi_d    = (state_d == ST_HI);
        pwm_lo_d    = (state_d == ST_LO) && (dt_onoff == DT_ON);
        dt_active_d = (state_d == ST_DT_HL) || (state_d == ST_DT_LH);
    end

    // State, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            pwm_hi_q    <= 1'b0;
            pwm_lo_q    <= 1'b0;
            dt_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwm_hi_q    <= pwm_hi_d;
            pwm_lo_q    <= pwm_lo_d;
            dt_active_q <= dt_active_d;
        end
    end

    assign pwm_hi    = pwm_hi_q;
    assign pwm_lo    = pwm_lo_q;
    assign dt_active = dt_active_q;

endmodule

// File: tb/tb_deadtime_gen.sv
// -----------------------------------------------------------------------------
// tb_deadtime_gen
//   Directed, table-driven bench for deadtime_gen. Each table row is a single
//   clock cycle: the inputs applied before the edge, and the expected
//   {pwm_hi, pwm_lo, dt_active} after it. Hand-written sequences cover the
//   disable and reset mid-count cases and the maximum dead time. A random
//   phase then exercises the no-overlap check.
// -----------------------------------------------------------------------------
module tb_deadtime_gen;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          pwm_in;
    logic [DW-1:0] dt_value;
    logic          pwm_onoff;
    logic          dt_onoff;
    logic          pwm_hi;
    logic          pwm_lo;
    logic          dt_active;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic          rst;
        logic          pin;
        logic [DW-1:0] dt;
        logic          on;
        logic          dton;
        logic [2:0]    exp_v;   // {pwm_hi, pwm_lo, dt_active}
        string         name;
    } vec_t;

    vec_t vecs[$];

    deadtime_gen #(.DT_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .dt_value  (dt_value),
        .pwm_onoff (pwm_onoff),
        .dt_onoff  (dt_onoff),
        .pwm_hi    (pwm_hi),
        .pwm_lo    (pwm_lo),
        .dt_active (dt_active)
    );

    always #5 clk = ~clk;

    // Gates must never be on together, in any cycle
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            assert (!(pwm_hi && pwm_lo)) else begin
                errors++;
                $display("FAIL overlap at %0t: pwm_hi=%b pwm_lo=%b required not both 1",
                         $time, pwm_hi, pwm_lo);
            end
        end
    end

    task automatic add(input int n, input logic r, input logic p, input logic [DW-1:0] d,
                       input logic on, input logic dn, input logic [2:0] e, input string nm);
        vec_t v;
        v.rst = r; v.pin = p; v.dt = d; v.on = on; v.dton = dn; v.exp_v = e; v.name = nm;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic p, input logic [DW-1:0] d,
                         input logic on, input logic dn);
        reset = r; pwm_in = p; dt_value = d; pwm_onoff = on; dt_onoff = dn;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic r, input logic p, input logic [DW-1:0] d,
                        input logic on, input logic dn, input logic [2:0] e, input string nm);
        drive(r, p, d, on, dn);
        checks++;
        if ({pwm_hi, pwm_lo, dt_active} !== e) begin
            errors++;
            $display("FAIL %s at %0t: hi/lo/dt got %b required %b",
                     nm, $time, {pwm_hi, pwm_lo, dt_active}, e);
        end
    endtask

    initial begin
        // rst, pwm_in, dt, on, dt_on, {hi,lo,dt}
        add(3, 1'b0, 1'b1, 10'd5, 1'b1, 1'b1, 3'b000, "reset_hold");
        add(5, 1'b1, 1'b1, 10'd5, 1'b1, 1'b1, 3'b001, "startup_dead");
        add(2, 1'b1, 1'b1, 10'd5, 1'b1, 1'b1, 3'b100, "startup_hi");
        add(5, 1'b1, 1'b0, 10'd5, 1'b1, 1'b1, 3'b001, "hl_dead");
        add(2, 1'b1, 1'b0, 10'd5, 1'b1, 1'b1, 3'b010, "hl_lo_on");
        add(5, 1'b1, 1'b1, 10'd5, 1'b1, 1'b1, 3'b001, "lh_dead");
        add(1, 1'b1, 1'b1, 10'd5, 1'b1, 1'b1, 3'b100, "lh_hi_on");
        add(2, 1'b1, 1'b0, 10'd5, 1'b1, 1'b1, 3'b001, "abort_dead");
        add(2, 1'b1, 1'b1, 10'd5, 1'b1, 1'b1, 3'b100, "abort_hi_back");
        add(4, 1'b1, 1'b0, 10'd0, 1'b1, 1'b1, 3'b010, "dt0_lo");
        add(4, 1'b1, 1'b1, 10'd0, 1'b1, 1'b1, 3'b100, "dt0_hi");
        add(4, 1'b1, 1'b0, 10'd0, 1'b1, 1'b1, 3'b010, "dt0_lo2");
        add(4, 1'b1, 1'b1, 10'd0, 1'b1, 1'b1, 3'b100, "dt0_hi2");
        add(3, 1'b1, 1'b0, 10'd3, 1'b1, 1'b0, 3'b001, "dtoff_dead_hl");
        add(2, 1'b1, 1'b0, 10'd3, 1'b1, 1'b0, 3'b000, "dtoff_lo_gated");
        add(3, 1'b1, 1'b1, 10'd3, 1'b1, 1'b0, 3'b001, "dtoff_dead_lh");
        add(2, 1'b1, 1'b1, 10'd3, 1'b1, 1'b0, 3'b100, "dtoff_hi");
        add(1, 1'b1, 1'b0, 10'd3, 1'b1, 1'b0, 3'b001, "dtoff_hi_fall");
        add(2, 1'b1, 1'b0, 10'd7, 1'b1, 1'b1, 3'b001, "dt_change_count");
        add(1, 1'b1, 1'b0, 10'd7, 1'b1, 1'b1, 3'b010, "dt_change_lo");
        add(2, 1'b1, 1'b0, 10'd7, 1'b0, 1'b1, 3'b000, "pwm_off");
        add(7, 1'b1, 1'b0, 10'd7, 1'b1, 1'b1, 3'b001, "restart_dead");
        add(1, 1'b1, 1'b0, 10'd7, 1'b1, 1'b1, 3'b010, "restart_lo");
        add(1, 1'b1, 1'b1, 10'd1, 1'b1, 1'b1, 3'b001, "dt1_dead");
        add(1, 1'b1, 1'b1, 10'd1, 1'b1, 1'b1, 3'b100, "dt1_hi");

        mon_en = 1'b1;
        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].pin, vecs[i].dt, vecs[i].on, vecs[i].dton,
                 vecs[i].exp_v, vecs[i].name);

        // Disable in the middle of a dead time (cnt=3), then restart high
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'd5, 1'b1, 1'b1, 3'b001, "t6_dead");
        step(1'b1, 1'b0, 10'd5, 1'b0, 1'b1, 3'b000, "t6_off");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 10'd4, 1'b1, 1'b1, 3'b001, "t6_re_dead");
        step(1'b1, 1'b1, 10'd4, 1'b1, 1'b1, 3'b100, "t6_re_hi");

        // Same scenario, with reset in the middle of the count
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'd5, 1'b1, 1'b1, 3'b001, "t6r_dead");
        step(1'b0, 1'b0, 10'd5, 1'b1, 1'b1, 3'b000, "t6r_reset");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 10'd4, 1'b1, 1'b1, 3'b001, "t6r_re_dead");
        step(1'b1, 1'b1, 10'd4, 1'b1, 1'b1, 3'b100, "t6r_re_hi");

        // Maximum dead time: 1023 dead cycles, then the low side turns on
        for (int i = 0; i < 1023; i++) step(1'b1, 1'b0, 10'd1023, 1'b1, 1'b1, 3'b001, "max_dead");
        step(1'b1, 1'b0, 10'd1023, 1'b1, 1'b1, 3'b010, "max_lo");

        // Random inputs; only the overlap monitor judges this phase
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                  DW'($urandom_range(0, 6)), ($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 1)));

        step(1'b0, 1'b1, 10'd2, 1'b1, 1'b1, 3'b000, "final_reset");

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
